// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

  // Arbiter FSM: waiting for a request, or holding a grant.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  // Width of a requester index for a requester count w.
  function automatic int unsigned idx_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of req starting just after last_id.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]         req,
  input  logic [$clog2(W)-1:0] last_id,
  output logic                 found,
  output logic [$clog2(W)-1:0] index
);

  localparam int unsigned IW = idx_width(W);

  // W is a power of two, so index arithmetic wraps naturally in IW bits.
  always_comb begin
    logic [IW-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= W; k++) begin
      cand = last_id + IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/team_dmux.sv
// Shared library demux: routes valid/data to slice (W-1-sel); other slices are 0.
module team_dmux #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 16
) (
  input  logic                 valid_i,
  input  logic [N-1:0]         din_i,
  input  logic [$clog2(W)-1:0] sel_i,
  output logic [W-1:0]         valid_o,
  output logic [W*N-1:0]       dout_o
);

  // Reverse-ordered slice routing.
  always_comb begin
    valid_o = '0;
    dout_o  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (sel_i == $clog2(W)'(W - 1 - i)) begin
        valid_o[i]       = valid_i;
        dout_o[i*N +: N] = din_i;
      end
    end
  end

endmodule

// File: rtl/team_mux.sv
// Shared library mux: dout is slice (W-1-sel) of the packed input vector.
module team_mux #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 16
) (
  input  logic [W*N-1:0]       din_i,
  input  logic [$clog2(W)-1:0] sel_i,
  output logic [N-1:0]         dout_o
);

  // Reverse-ordered slice select.
  always_comb begin
    dout_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (sel_i == $clog2(W)'(W - 1 - i)) begin
        dout_o = din_i[i*N +: N];
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting W requesters onto one shared bus, with a
// combinational response router back to the requesters.
// Optional: define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned N         = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         req,
  input  logic [W*N-1:0]       req_data,
  output logic [W-1:0]         req_ready,
  output logic                 bus_valid,
  output logic [N-1:0]         bus_data,
  output logic [$clog2(W)-1:0] bus_id,
  input  logic                 bus_ready,
  input  logic                 rsp_valid,
  input  logic [$clog2(W)-1:0] rsp_id,
  input  logic [N-1:0]         rsp_data,
  output logic [W-1:0]         req_rsp_valid,
  output logic [W*N-1:0]       req_rsp_data
);

  localparam int unsigned IW = idx_width(W);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] last_id_q, last_id_d;
  logic          pick_found;
  logic [IW-1:0] pick_id;
  logic [IW-1:0] mux_sel;
  logic [IW-1:0] dmux_sel;
  logic [N-1:0]  mux_data;
  logic          xfer;

  rr_pick #(
    .W(W)
  ) u_pick (
    .req    (req),
    .last_id(last_id_q),
    .found  (pick_found),
    .index  (pick_id)
  );

  // Library blocks select slice W-1-sel, so pre-invert to get slice i for index i.
  assign mux_sel  = IW'(W - 1) - gnt_id_q;
  assign dmux_sel = IW'(W - 1) - rsp_id;

  team_mux #(
    .W(W),
    .N(N)
  ) u_mux (
    .din_i (req_data),
    .sel_i (mux_sel),
    .dout_o(mux_data)
  );

  team_dmux #(
    .W(W),
    .N(N)
  ) u_dmux (
    .valid_i(rsp_valid),
    .din_i  (rsp_data),
    .sel_i  (dmux_sel),
    .valid_o(req_rsp_valid),
    .dout_o (req_rsp_data)
  );

  // Bus-side outputs; all handshake outputs stay quiet outside GRANT.
  always_comb begin
    bus_valid = (state_q == StGrant) && req[gnt_id_q];
    bus_id    = (state_q == StGrant) ? gnt_id_q : '0;
    bus_data  = mux_data;
    xfer      = bus_valid && bus_ready;
    req_ready = xfer ? (W'(1) << gnt_id_q) : '0;
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          burst_done;

  assign burst_done = xfer && (beat_cnt_q == CW'(MAX_BURST - 1));
`else
  logic burst_done;
  logic unused_max_burst;

  assign burst_done       = 1'b0;
  assign unused_max_burst = ^MAX_BURST;
`endif

  // Next-state: pick in IDLE, release when the holder drops or the burst cap hits.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d  = StGrant;
          gnt_id_d = pick_id;
        end
      end
      StGrant: begin
        if (!req[gnt_id_q] || burst_done) begin
          state_d   = StIdle;
          last_id_d = gnt_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and grant bookkeeping; last_id resets to W-1 so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_id_q  <= '0;
      last_id_q <= IW'(W - 1);
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  // Beat counter: counts transfers within a grant, cleared whenever the FSM returns to IDLE.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d == StIdle) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter (W=4, N=8, MAX_BURST=4).
// Honours ARB_BURST_LIMIT_EN the same way as the design.
module tb_rr_bus_arbiter;

  localparam int W = 4;
  localparam int N = 8;
  localparam int MaxBurst = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   req;
  logic [W*N-1:0] req_data;
  logic [W-1:0]   req_ready;
  logic           bus_valid;
  logic [N-1:0]   bus_data;
  logic [1:0]     bus_id;
  logic           bus_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_data;
  logic [W-1:0]   req_rsp_valid;
  logic [W*N-1:0] req_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who holds the bus (-1 = nobody), last holder, beats in this grant.
  int m_owner = -1;
  int m_last  = W - 1;
  int m_beats = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(
    .W(W),
    .N(N),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .bus_valid    (bus_valid),
    .bus_data     (bus_data),
    .bus_id       (bus_id),
    .bus_ready    (bus_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .req_rsp_valid(req_rsp_valid),
    .req_rsp_data (req_rsp_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against what the model says for the current inputs.
  task automatic check_model();
    logic        e_valid;
    logic [31:0] e_ready, e_rsp_data;
    e_valid = (m_owner >= 0) && req[m_owner];
    e_ready = (e_valid && bus_ready) ? (32'd1 << m_owner) : 32'd0;
    e_rsp_data = 32'(rsp_data) << (N * int'(rsp_id));
    check_eq("bus_valid", 32'(bus_valid), 32'(e_valid));
    check_eq("bus_id", 32'(bus_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_eq("req_ready", 32'(req_ready), e_ready);
    if (e_valid) check_eq("bus_data", 32'(bus_data), 32'(req_data[m_owner*N +: N]));
    check_eq("rsp_valid", 32'(req_rsp_valid), rsp_valid ? (32'd1 << rsp_id) : 32'd0);
    check_eq("rsp_data", req_rsp_data, e_rsp_data);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1;
      m_last  = W - 1;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= W; k++) begin
        int c;
        c = (m_last + k) % W;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_beats = 0;
    end else if (bus_ready) begin
      m_beats++;
      if (BurstEn && m_beats == MaxBurst) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  // Check current cycle, then clock once; returns at posedge+1.
  task automatic cyc();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit seen;

    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    bus_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    @(posedge clk);
    #1;
    do_reset();
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_id", 32'(bus_id), 32'd0);

    // Grant to lowest index first, then rotate to 2.
    req_data  = 32'h44332211;
    req       = 4'b0101;
    bus_ready = 1'b1;
    cyc();
    check_eq("first_id", 32'(bus_id), 32'd0);
    check_eq("first_valid", 32'(bus_valid), 32'd1);
    cyc();
    req = 4'b0100;
    cyc();
    cyc();
    check_eq("second_id", 32'(bus_id), 32'd2);
    check_eq("second_valid", 32'(bus_valid), 32'd1);

    // All request, each drops after one beat: order must wrap 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        if (bus_valid) seen = 1'b1;
        else cyc();
      end
      check_eq("wrap_grant_seen", 32'(seen), 32'd1);
      order[g] = int'(bus_id);
      cyc();
      req[order[g]] = 1'b0;
      cyc();
      req = 4'b1111;
    end
    for (int g = 0; g < 5; g++) check_eq("wrap_order", 32'(order[g]), 32'(exp_order[g]));

    // Stalled bus: payload held, ready only in the accept cycle.
    do_reset();
    req       = 4'b0010;
    req_data  = 32'h0000A500;
    bus_ready = 1'b0;
    cyc();
    for (int t = 0; t < 3; t++) begin
      check_eq("stall_data", 32'(bus_data), 32'hA5);
      check_eq("stall_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    bus_ready = 1'b1;
    #1;
    check_eq("accept_data", 32'(bus_data), 32'hA5);
    check_eq("accept_ready", 32'(req_ready), 32'b0010);
    cyc();
    req = '0;
    cyc();

    // Response routing to requester 3.
    rsp_valid = 1'b1;
    rsp_id    = 2'd3;
    rsp_data  = 8'h3C;
    #1;
    check_eq("rsp3_valid", 32'(req_rsp_valid), 32'b1000);
    check_eq("rsp3_data", req_rsp_data, 32'h3C000000);
    rsp_valid = 1'b0;

    // Burst cap behaviour with two persistent requesters.
    do_reset();
    req       = 4'b0011;
    bus_ready = 1'b1;
    cyc();
    for (int b = 0; b < 4; b++) begin
      check_eq("burst_id0", 32'(bus_id), 32'd0);
      check_eq("burst_valid", 32'(bus_valid), 32'd1);
      cyc();
    end
`ifdef ARB_BURST_LIMIT_EN
    check_eq("burst_idle", 32'(bus_valid), 32'd0);
    cyc();
    check_eq("burst_next_id", 32'(bus_id), 32'd1);
    check_eq("burst_next_valid", 32'(bus_valid), 32'd1);
`else
    for (int b = 0; b < 3; b++) begin
      check_eq("hold_id0", 32'(bus_id), 32'd0);
      check_eq("hold_valid", 32'(bus_valid), 32'd1);
      cyc();
    end
`endif

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b0011;
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    check_eq("midrst_valid", 32'(bus_valid), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    cyc();
    check_eq("midrst_regrant", 32'(bus_id), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(3) == 0) req[i] = ~req[i];
      req_data  = $urandom;
      bus_ready = ($urandom_range(3) != 0);
      rsp_valid = $urandom_range(1);
      rsp_id    = 2'($urandom_range(3));
      rsp_data  = 8'($urandom);
      rst_n     = ($urandom_range(199) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
